// File: rtl/maze_env_step_if.sv
// Action handshake between the agent core and the maze step engine.
interface maze_env_step_if;
  logic       action_valid;
  logic [1:0] action;
  logic       action_ready;

  modport master (
    output action_valid,
    output action,
    input  action_ready
  );

  modport slave (
    input  action_valid,
    input  action,
    output action_ready
  );
endinterface

// File: rtl/maze_env_step.sv
// Grid-world step engine: 10x10 maze with edge/obstacle rules,
// reward and episode-termination reporting per accepted action.
module maze_env_step #(
  parameter int unsigned START_LOC   = 0,
  parameter int unsigned GOAL_LOC    = 99,
  parameter logic [99:0] OBSTACLES   = '0,
  parameter int unsigned MAX_STEPS   = 200,
  parameter int          REWARD_GOAL = 100,
  parameter int          REWARD_STEP = -1,
  parameter int          REWARD_WALL = -5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ep_start,
  maze_env_step_if.slave        act,
  output logic [7:0]            state,
  output logic                  state_valid,
  output logic [7:0]            reward,
  output logic                  done,
  output logic                  timeout,
  output logic [7:0]            step_count
);

  localparam logic [3:0] START_ROW = 4'(START_LOC / 10);
  localparam logic [3:0] START_COL = 4'(START_LOC % 10);
  localparam logic [7:0] START_IDX = 8'(START_LOC);
  localparam logic [6:0] GOAL_CELL = 7'(GOAL_LOC);
  localparam logic [7:0] MAX_CNT   = 8'(MAX_STEPS);
  localparam logic [7:0] RW_GOAL   = 8'(REWARD_GOAL);
  localparam logic [7:0] RW_STEP   = 8'(REWARD_STEP);
  localparam logic [7:0] RW_WALL   = 8'(REWARD_WALL);
  // Start and goal cells are always enterable.
  localparam logic [99:0] BLOCKED  = OBSTACLES
                                   & ~(100'd1 << START_LOC)
                                   & ~(100'd1 << GOAL_LOC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_MOVE,
    S_RESP
  } fsm_e;

  fsm_e       fsm_q, fsm_d;
  logic [3:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic [1:0] act_q, act_d;
  logic [7:0] state_q, state_d;
  logic [7:0] reward_q, reward_d;
  logic [7:0] count_q, count_d;
  logic       valid_q, valid_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       tmo_q, tmo_d;

  logic [3:0] nrow, ncol;
  logic       hit_edge;
  logic [6:0] cand;
  logic       blocked;
  logic       at_goal;
  logic [7:0] count_inc;

  always_comb begin
    nrow     = row_q;
    ncol     = col_q;
    hit_edge = 1'b0;
    case (act_q)
      2'd0: if (row_q == 4'd0) hit_edge = 1'b1;
            else nrow = row_q - 4'd1;
      2'd1: if (col_q == 4'd9) hit_edge = 1'b1;
            else ncol = col_q + 4'd1;
      2'd2: if (row_q == 4'd9) hit_edge = 1'b1;
            else nrow = row_q + 4'd1;
      default: if (col_q == 4'd0) hit_edge = 1'b1;
               else ncol = col_q - 4'd1;
    endcase
  end

  // row*10 + col via shifts
  assign cand = {nrow, 3'b000}
              + {2'b00, nrow, 1'b0}
              + {3'b000, ncol};
  assign blocked   = hit_edge | BLOCKED[cand];
  assign at_goal   = ~blocked & (cand == GOAL_CELL);
  assign count_inc = (count_q == MAX_CNT) ? count_q
                                          : count_q + 8'd1;

  always_comb begin
    fsm_d    = fsm_q;
    row_d    = row_q;
    col_d    = col_q;
    act_d    = act_q;
    state_d  = state_q;
    reward_d = reward_q;
    count_d  = count_q;
    valid_d  = 1'b0;
    done_d   = done_q;
    tmo_d    = tmo_q;
    if (ep_start && fsm_q != S_START) begin
      fsm_d = S_START;
    end else begin
      unique case (fsm_q)
        S_IDLE: fsm_d = S_IDLE;
        S_START: begin
          row_d    = START_ROW;
          col_d    = START_COL;
          state_d  = START_IDX;
          reward_d = 8'd0;
          count_d  = 8'd0;
          done_d   = 1'b0;
          tmo_d    = 1'b0;
          valid_d  = 1'b1;
          fsm_d    = S_RESP;
        end
        S_WAIT: begin
          if (act.action_valid && act.action_ready) begin
            act_d = act.action;
            fsm_d = S_MOVE;
          end
        end
        S_MOVE: begin
          count_d = count_inc;
          valid_d = 1'b1;
          fsm_d   = S_RESP;
          if (blocked) begin
            reward_d = RW_WALL;
          end else begin
            row_d    = nrow;
            col_d    = ncol;
            state_d  = {1'b0, cand};
            reward_d = at_goal ? RW_GOAL : RW_STEP;
          end
          done_d = at_goal | (count_inc == MAX_CNT);
          tmo_d  = ~at_goal & (count_inc == MAX_CNT);
        end
        S_RESP: fsm_d = done_q ? S_IDLE : S_WAIT;
        default: fsm_d = S_IDLE;
      endcase
    end
    ready_d = (fsm_d == S_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= S_IDLE;
      row_q    <= START_ROW;
      col_q    <= START_COL;
      act_q    <= 2'd0;
      state_q  <= START_IDX;
      reward_q <= 8'd0;
      count_q  <= 8'd0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      row_q    <= row_d;
      col_q    <= col_d;
      act_q    <= act_d;
      state_q  <= state_d;
      reward_q <= reward_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
    end
  end

  assign act.action_ready = ready_q & ~ep_start;
  assign state            = state_q;
  assign state_valid      = valid_q;
  assign reward           = reward_q;
  assign done             = done_q;
  assign timeout          = tmo_q;
  assign step_count       = count_q;

endmodule

// File: tb/tb_maze_env_step.sv
// Scoreboard bench for maze_env_step: two configurations,
// directed episodes plus random walks against a grid model.
module tb_maze_env_step;

  localparam logic [99:0] OBS1 = (100'd1 << 0) | (100'd1 << 1)
                               | (100'd1 << 12) | (100'd1 << 23)
                               | (100'd1 << 30) | (100'd1 << 34)
                               | (100'd1 << 45) | (100'd1 << 56);

  typedef struct packed {
    logic [7:0] st;
    logic [7:0] rw;
    logic       dn;
    logic       to;
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  logic ep_s [2];
  logic [7:0] o_st [2];
  logic       o_sv [2];
  logic [7:0] o_rw [2];
  logic       o_dn [2];
  logic       o_to [2];
  logic [7:0] o_cnt [2];
  logic       o_rdy [2];

  maze_env_step_if if0 ();
  maze_env_step_if if1 ();

  assign o_rdy[0] = if0.action_ready;
  assign o_rdy[1] = if1.action_ready;

  maze_env_step u_dut0 (
    .clk(clk), .rst_n(rst_n), .ep_start(ep_s[0]), .act(if0),
    .state(o_st[0]), .state_valid(o_sv[0]), .reward(o_rw[0]),
    .done(o_dn[0]), .timeout(o_to[0]), .step_count(o_cnt[0])
  );

  maze_env_step #(
    .START_LOC(0), .GOAL_LOC(30), .OBSTACLES(OBS1), .MAX_STEPS(3)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ep_start(ep_s[1]), .act(if1),
    .state(o_st[1]), .state_valid(o_sv[1]), .reward(o_rw[1]),
    .done(o_dn[1]), .timeout(o_to[1]), .step_count(o_cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  exp_t q0 [$];
  exp_t q1 [$];

  int          m_start [2];
  int          m_goal [2];
  int          m_max [2];
  logic [99:0] m_obs [2];
  int          m_cell [2];
  int          m_cnt [2];
  bit          m_done [2];

  bit chk_rdy [2];
  bit rdy_exp [2];

  task automatic chk(input bit ok, input string name,
                     input int got, input int want);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int u, input exp_t e);
    if (u == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic set_act(input int u, input logic v, input logic [1:0] a);
    if (u == 0) begin
      if0.action_valid = v;
      if0.action = a;
    end else begin
      if1.action_valid = v;
      if1.action = a;
    end
  endtask

  // Reference: plain row/col arithmetic on the cell index.
  task automatic model_step(input int u, input int a, output exp_t e);
    int r, c, nr, nc, nxt, rw;
    bit wall, goal;
    r = m_cell[u] / 10;
    c = m_cell[u] % 10;
    nr = r;
    nc = c;
    case (a)
      0: nr = r - 1;
      1: nc = c + 1;
      2: nr = r + 1;
      default: nc = c - 1;
    endcase
    wall = (nr < 0) || (nr > 9) || (nc < 0) || (nc > 9);
    nxt = nr * 10 + nc;
    if (!wall && nxt != m_start[u] && nxt != m_goal[u] && m_obs[u][nxt])
      wall = 1'b1;
    goal = 1'b0;
    if (wall) begin
      rw = -5;
    end else begin
      m_cell[u] = nxt;
      goal = (nxt == m_goal[u]);
      rw = goal ? 100 : -1;
    end
    m_cnt[u]++;
    e.st = 8'(m_cell[u]);
    e.rw = 8'(rw);
    e.cnt = 8'(m_cnt[u]);
    e.dn = goal || (m_cnt[u] == m_max[u]);
    e.to = !goal && (m_cnt[u] == m_max[u]);
    m_done[u] = e.dn;
  endtask

  task automatic drain(input int u);
    int n = 0;
    while (qsize(u) > 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(qsize(u) == 0, "resp_timeout", qsize(u), 0);
    if (u == 0) q0.delete();
    else q1.delete();
  endtask

  task automatic start_ep(input int u);
    exp_t e;
    m_cell[u] = m_start[u];
    m_cnt[u] = 0;
    m_done[u] = 1'b0;
    e.st = 8'(m_start[u]);
    e.rw = 8'd0;
    e.dn = 1'b0;
    e.to = 1'b0;
    e.cnt = 8'd0;
    ep_s[u] = 1'b1;
    push(u, e);
    @(posedge clk); #1;
    ep_s[u] = 1'b0;
    drain(u);
  endtask

  task automatic wait_ready(input int u);
    int n = 0;
    while (!o_rdy[u] && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk(o_rdy[u] == 1'b1, "ready_wait", int'(o_rdy[u]), 1);
  endtask

  task automatic do_action(input int u, input int a, input bit abort);
    exp_t e;
    wait_ready(u);
    if (!o_rdy[u]) return;
    set_act(u, 1'b1, 2'(a));
    @(posedge clk); #1;
    set_act(u, 1'b0, 2'd0);
    if (abort) begin
      start_ep(u);
    end else begin
      model_step(u, a, e);
      push(u, e);
      drain(u);
    end
  endtask

  task automatic reject(input int u);
    set_act(u, 1'b1, 2'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk(o_rdy[u] == 1'b0, "no_accept_after_done", int'(o_rdy[u]), 0);
    end
    set_act(u, 1'b0, 2'd0);
  endtask

  task automatic check_reset(input int u);
    chk(o_st[u] == 8'(m_start[u]), "rst_state", int'(o_st[u]), m_start[u]);
    chk(o_sv[u] == 1'b0, "rst_valid", int'(o_sv[u]), 0);
    chk(o_rw[u] == 8'd0, "rst_reward", int'(o_rw[u]), 0);
    chk(o_dn[u] == 1'b0, "rst_done", int'(o_dn[u]), 0);
    chk(o_to[u] == 1'b0, "rst_timeout", int'(o_to[u]), 0);
    chk(o_cnt[u] == 8'd0, "rst_count", int'(o_cnt[u]), 0);
    chk(o_rdy[u] == 1'b0, "rst_ready", int'(o_rdy[u]), 0);
  endtask

  // Monitor: pops expected responses on every state_valid pulse.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      exp_t e, g;
      if (chk_rdy[u] && rst_n && !ep_s[u])
        chk(o_rdy[u] == rdy_exp[u], "ready_after_resp",
            int'(o_rdy[u]), int'(rdy_exp[u]));
      chk_rdy[u] = 1'b0;
      if (o_sv[u] && rst_n) begin
        if (qsize(u) == 0) begin
          chk(1'b0, "unexpected_pulse", int'(o_st[u]), -1);
        end else begin
          if (u == 0) e = q0.pop_front();
          else e = q1.pop_front();
          g.st = o_st[u];
          g.rw = o_rw[u];
          g.dn = o_dn[u];
          g.to = o_to[u];
          g.cnt = o_cnt[u];
          n_checks++;
          if (g != e) begin
            n_fail++;
            $display("FAIL resp u%0d: got st=%0d rw=%0d dn=%0b to=%0b cnt=%0d want st=%0d rw=%0d dn=%0b to=%0b cnt=%0d",
                     u, g.st, $signed(g.rw), g.dn, g.to, g.cnt,
                     e.st, $signed(e.rw), e.dn, e.to, e.cnt);
          end
          chk(o_rdy[u] == 1'b0, "ready_in_pulse", int'(o_rdy[u]), 0);
          chk_rdy[u] = 1'b1;
          rdy_exp[u] = !e.dn;
        end
      end
    end
  end

  initial begin
    exp_t e;
    int n;
    m_start[0] = 0;  m_goal[0] = 99; m_max[0] = 200; m_obs[0] = '0;
    m_start[1] = 0;  m_goal[1] = 30; m_max[1] = 3;   m_obs[1] = OBS1;
    for (int u = 0; u < 2; u++) begin
      ep_s[u] = 1'b0;
      m_cell[u] = 0;
      m_cnt[u] = 0;
      m_done[u] = 1'b1;
      chk_rdy[u] = 1'b0;
      rdy_exp[u] = 1'b0;
      set_act(u, 1'b0, 2'd0);
    end
    rst_n = 1'b0;
    #3;
    check_reset(0);
    check_reset(1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk(o_rdy[0] == 1'b0, "idle_ready", int'(o_rdy[0]), 0);

    start_ep(0);
    for (int i = 0; i < 9; i++) do_action(0, 1, 1'b0);
    for (int i = 0; i < 9; i++) do_action(0, 2, 1'b0);
    chk(o_st[0] == 8'd99, "goal_state", int'(o_st[0]), 99);
    chk(o_cnt[0] == 8'd18, "goal_count", int'(o_cnt[0]), 18);
    reject(0);

    start_ep(0);
    do_action(0, 0, 1'b0);
    do_action(0, 3, 1'b0);
    chk(o_rw[0] == 8'hFB, "wall_reward", int'(o_rw[0]), 251);

    start_ep(1);
    do_action(1, 1, 1'b0);
    do_action(1, 2, 1'b0);
    do_action(1, 1, 1'b0);
    reject(1);

    start_ep(1);
    do_action(1, 2, 1'b0);
    do_action(1, 1, 1'b0);
    do_action(1, 2, 1'b0);
    chk(o_to[1] == 1'b1, "timeout_flag", int'(o_to[1]), 1);
    reject(1);

    start_ep(1);
    for (int i = 0; i < 3; i++) do_action(1, 2, 1'b0);
    chk(o_to[1] == 1'b0, "goal_over_timeout", int'(o_to[1]), 0);

    start_ep(0);
    do_action(0, 1, 1'b0);
    do_action(0, 1, 1'b1);

    for (int i = 0; i < 160; i++) begin
      int u;
      u = int'($urandom_range(0, 1));
      if (m_done[u] || $urandom_range(0, 15) == 0) start_ep(u);
      else do_action(u, int'($urandom_range(0, 3)), 1'b0);
    end

    start_ep(0);
    wait_ready(0);
    set_act(0, 1'b1, 2'd2);
    @(posedge clk); #1;
    set_act(0, 1'b0, 2'd0);
    model_step(0, 2, e);
    push(0, e);
    n = 0;
    while (!o_sv[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(o_sv[0] == 1'b1, "resp_for_reset", int'(o_sv[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset(0);
    check_reset(1);
    q0.delete();
    q1.delete();
    m_done[0] = 1'b1;
    m_done[1] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_ep(1);
    do_action(1, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
